// File: rtl/button_pkg.sv
// Shared types and default timing for the push-button conditioning slice.
// Contents:
//   btn_state_t             - conditioner FSM state
//   DefaultDebounceCycles   - 10 ms stability window at the 12 MHz board clock
//   DefaultLongPressCycles  - 0.5 s hold window at the 12 MHz board clock
package button_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PRESS_DB,
        PRESSED,
        LONG_HELD,
        RELEASE_DB
    } btn_state_t;

    localparam int unsigned DefaultDebounceCycles  = 120000;
    localparam int unsigned DefaultLongPressCycles = 6000000;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous pad input.
// Ports:
//   clk  in   clock of the destination domain
//   rst  in   synchronous, active-high; loads RESET_VAL into both flops
//   d    in   asynchronous input
//   q    out  synchronized copy of d, two cycles of latency
module sync_2ff #(
    parameter bit RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= RESET_VAL;
            q      <= RESET_VAL;
        end else begin
            meta_q <= d;
            q      <= meta_q;
        end
    end

endmodule

// File: rtl/button_conditioner.sv
// Push-button conditioner: turns a raw, bouncy, asynchronous button into clean
// single-cycle events in the clk domain, plus a debounced level and a long-press event.
// Ports:
//   clk            in   system clock
//   rst            in   synchronous, active-high reset
//   ena            in   block enable; low forces idle and clears all outputs
//   button_raw     in   asynchronous pad input
//   button_level   out  debounced pressed level (registered)
//   press_pulse    out  one-cycle strobe on an accepted press
//   release_pulse  out  one-cycle strobe on an accepted release
//   long_pulse     out  one-cycle strobe when the hold reaches LONG_PRESS_CYCLES
module button_conditioner
    import button_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES   = DefaultDebounceCycles,
    parameter int unsigned LONG_PRESS_CYCLES = DefaultLongPressCycles,
    parameter bit          ACTIVE_LOW        = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic ena,
    input  logic button_raw,
    output logic button_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_pulse
);

    localparam int unsigned DebW  = $clog2(DEBOUNCE_CYCLES);
    localparam int unsigned HoldW = $clog2(LONG_PRESS_CYCLES);

    localparam logic [DebW-1:0]  DebLast  = DebW'(DEBOUNCE_CYCLES - 1);
    localparam logic [DebW-1:0]  DebOne   = DebW'(1);
    localparam logic [HoldW-1:0] HoldLast = HoldW'(LONG_PRESS_CYCLES - 1);
    localparam logic [HoldW-1:0] HoldOne  = HoldW'(1);

    logic sync_out;
    logic s;

    btn_state_t       state_q, state_d;
    logic [DebW-1:0]  deb_q, deb_d;
    logic [HoldW-1:0] hold_q, hold_d;
    logic             long_fired_q, long_fired_d;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic             rel_q, rel_d;
    logic             long_q, long_d;

    // Synchronizer resets to the pad's idle level so s reads "not pressed".
    sync_2ff #(
        .RESET_VAL (ACTIVE_LOW)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (button_raw),
        .q   (sync_out)
    );

    assign s = sync_out ^ ACTIVE_LOW;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            deb_q        <= '0;
            hold_q       <= '0;
            long_fired_q <= 1'b0;
            level_q      <= 1'b0;
            press_q      <= 1'b0;
            rel_q        <= 1'b0;
            long_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            deb_q        <= deb_d;
            hold_q       <= hold_d;
            long_fired_q <= long_fired_d;
            level_q      <= level_d;
            press_q      <= press_d;
            rel_q        <= rel_d;
            long_q       <= long_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        deb_d        = deb_q;
        hold_d       = hold_q;
        long_fired_d = long_fired_q;
        level_d      = level_q;
        press_d      = 1'b0;
        rel_d        = 1'b0;
        long_d       = 1'b0;

        if (!ena) begin
            // Disable drops straight to idle without announcing a release.
            state_d      = IDLE;
            deb_d        = '0;
            hold_d       = '0;
            long_fired_d = 1'b0;
            level_d      = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (s) begin
                        state_d = PRESS_DB;
                        deb_d   = '0;
                    end
                end
                PRESS_DB: begin
                    if (!s) begin
                        state_d = IDLE;
                    end else if (deb_q == DebLast) begin
                        state_d      = PRESSED;
                        press_d      = 1'b1;
                        level_d      = 1'b1;
                        hold_d       = '0;
                        long_fired_d = 1'b0;
                    end else begin
                        deb_d = deb_q + DebOne;
                    end
                end
                PRESSED: begin
                    // hold_q is left untouched on exit so a rejected release resumes it.
                    if (!s) begin
                        state_d = RELEASE_DB;
                        deb_d   = '0;
                    end else if (hold_q == HoldLast) begin
                        state_d      = LONG_HELD;
                        long_d       = 1'b1;
                        long_fired_d = 1'b1;
                    end else begin
                        hold_d = hold_q + HoldOne;
                    end
                end
                LONG_HELD: begin
                    if (!s) begin
                        state_d = RELEASE_DB;
                        deb_d   = '0;
                    end
                end
                RELEASE_DB: begin
                    if (s) begin
                        state_d = long_fired_q ? LONG_HELD : PRESSED;
                    end else if (deb_q == DebLast) begin
                        state_d      = IDLE;
                        rel_d        = 1'b1;
                        level_d      = 1'b0;
                        long_fired_d = 1'b0;
                    end else begin
                        deb_d = deb_q + DebOne;
                    end
                end
                default: begin
                    state_d      = IDLE;
                    deb_d        = '0;
                    hold_d       = '0;
                    long_fired_d = 1'b0;
                    level_d      = 1'b0;
                end
            endcase
        end
    end

    assign button_level  = level_q;
    assign press_pulse   = press_q;
    assign release_pulse = rel_q;
    assign long_pulse    = long_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: two instances (active-high and active-low pads),
// a run-length reference model compared every cycle, and hand-timed directed checks.
module tb_button_conditioner;

    localparam int unsigned D = 4;
    localparam int unsigned L = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, ena, raw0, raw1;
    logic lvl0, pp0, rp0, lp0;
    logic lvl1, pp1, rp1, lp1;

    button_conditioner #(
        .DEBOUNCE_CYCLES   (D),
        .LONG_PRESS_CYCLES (L),
        .ACTIVE_LOW        (1'b0)
    ) u_dut0 (
        .clk           (clk),
        .rst           (rst),
        .ena           (ena),
        .button_raw    (raw0),
        .button_level  (lvl0),
        .press_pulse   (pp0),
        .release_pulse (rp0),
        .long_pulse    (lp0)
    );

    button_conditioner #(
        .DEBOUNCE_CYCLES   (D),
        .LONG_PRESS_CYCLES (L),
        .ACTIVE_LOW        (1'b1)
    ) u_dut1 (
        .clk           (clk),
        .rst           (rst),
        .ena           (ena),
        .button_raw    (raw1),
        .button_level  (lvl1),
        .press_pulse   (pp1),
        .release_pulse (rp1),
        .long_pulse    (lp1)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: a press/release is accepted once the synchronized input has
    // disagreed with the accepted level for D+1 consecutive clock edges. The long press
    // counts edges where the button was already accepted as held and the input stayed
    // high on this and the previous edge.
    bit m_al    [2] = '{1'b0, 1'b1};
    bit m_sy1   [2];
    bit m_sy2   [2];
    bit m_sprev [2];
    bit m_lvl   [2];
    bit m_press [2];
    bit m_rel   [2];
    bit m_long  [2];
    bit m_fired [2];
    int m_run   [2];
    int m_hold  [2];
    bit m_valid = 1'b0;
    bit mr, ms;

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            mr = (i == 0) ? raw0 : raw1;
            m_press[i] = 1'b0;
            m_rel[i]   = 1'b0;
            m_long[i]  = 1'b0;
            if (rst) begin
                m_sy1[i]   = m_al[i];
                m_sy2[i]   = m_al[i];
                m_sprev[i] = 1'b0;
                m_lvl[i]   = 1'b0;
                m_fired[i] = 1'b0;
                m_run[i]   = 0;
                m_hold[i]  = 0;
            end else begin
                ms = m_sy2[i] ^ m_al[i];
                if (!ena) begin
                    m_lvl[i]   = 1'b0;
                    m_fired[i] = 1'b0;
                    m_run[i]   = 0;
                    m_hold[i]  = 0;
                end else begin
                    if (m_lvl[i] && ms && m_sprev[i] && !m_fired[i]) begin
                        m_hold[i]++;
                        if (m_hold[i] == L) begin
                            m_long[i]  = 1'b1;
                            m_fired[i] = 1'b1;
                        end
                    end
                    if (ms != m_lvl[i]) m_run[i]++;
                    else                m_run[i] = 0;
                    if (m_run[i] == D + 1) begin
                        m_run[i] = 0;
                        m_lvl[i] = !m_lvl[i];
                        if (m_lvl[i]) begin
                            m_press[i] = 1'b1;
                            m_hold[i]  = 0;
                        end else begin
                            m_rel[i]   = 1'b1;
                            m_fired[i] = 1'b0;
                        end
                    end
                end
                m_sprev[i] = ms;
                m_sy2[i]   = m_sy1[i];
                m_sy1[i]   = mr;
            end
        end
        m_valid = 1'b1;
    end

    int n_press0 = 0, n_rel0 = 0, n_long0 = 0;

    always @(negedge clk) begin
        if (m_valid) begin
            chk("model_level0",   int'(lvl0), int'(m_lvl[0]));
            chk("model_press0",   int'(pp0),  int'(m_press[0]));
            chk("model_release0", int'(rp0),  int'(m_rel[0]));
            chk("model_long0",    int'(lp0),  int'(m_long[0]));
            chk("model_level1",   int'(lvl1), int'(m_lvl[1]));
            chk("model_press1",   int'(pp1),  int'(m_press[1]));
            chk("model_release1", int'(rp1),  int'(m_rel[1]));
            chk("model_long1",    int'(lp1),  int'(m_long[1]));
            n_press0 += int'(pp0);
            n_rel0   += int'(rp0);
            n_long0  += int'(lp0);
        end
    end

    // Advance to just after the n-th following falling edge.
    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    int snap_p, snap_r;

    initial begin
        rst  = 1'b1;
        ena  = 1'b1;
        raw0 = 1'b0;
        raw1 = 1'b1;
        step(2);
        chk("reset_level0", int'(lvl0), 0);
        chk("reset_press0", int'(pp0),  0);
        chk("reset_level1", int'(lvl1), 0);
        chk("reset_press1", int'(pp1),  0);
        rst = 1'b0;
        step(3);

        // Clean press held long enough for a long press, then released.
        raw0 = 1'b1;
        step(6);  chk("t1_no_press_e6", int'(pp0), 0);
        step(1);  chk("t1_press_e7", int'(pp0), 1);
        chk("t1_level_e7", int'(lvl0), 1);
        step(1);  chk("t1_press_single", int'(pp0), 0);
        step(8);  chk("t3_no_long_e16", int'(lp0), 0);
        step(1);  chk("t3_long_e17", int'(lp0), 1);
        step(13); chk("t3_long_once", n_long0, 1);
        raw0 = 1'b0;
        step(6);  chk("t3_no_release_r6", int'(rp0), 0);
        chk("t3_level_held_r6", int'(lvl0), 1);
        step(1);  chk("t3_release_r7", int'(rp0), 1);
        chk("t3_level_fall", int'(lvl0), 0);
        step(1);  chk("t3_release_single", int'(rp0), 0);
        step(3);

        // Bounce shorter than the debounce window.
        snap_p = n_press0;
        repeat (5) begin
            raw0 = 1'b1; step(3);
            raw0 = 1'b0; step(2);
        end
        step(6);
        chk("t2_no_press", n_press0 - snap_p, 0);
        chk("t2_level_low", int'(lvl0), 0);

        // Release bounce during hold: no release, long press delayed by 3 edges.
        raw0 = 1'b1;
        step(7);  chk("t4_press", int'(pp0), 1);
        snap_r = n_rel0;
        step(2);  raw0 = 1'b0;
        step(2);  raw0 = 1'b1;
        step(8);  chk("t4_no_long_p12", int'(lp0), 0);
        step(1);  chk("t4_long_p13", int'(lp0), 1);
        chk("t4_no_release", n_rel0 - snap_r, 0);
        chk("t4_level_high", int'(lvl0), 1);
        step(2);

        // Disable while held, then re-enable with the button still down.
        snap_r = n_rel0;
        ena = 1'b0;
        step(1);  chk("t5_level_off", int'(lvl0), 0);
        chk("t5_no_release_pulse", int'(rp0), 0);
        step(4);  chk("t5_no_release_cnt", n_rel0 - snap_r, 0);
        ena = 1'b1;
        step(4);  chk("t5_no_press_f4", int'(pp0), 0);
        step(1);  chk("t5_press_f5", int'(pp0), 1);
        raw0 = 1'b0;
        step(10);

        // Reset in the middle of a press debounce.
        raw0 = 1'b1;
        step(4);
        snap_p = n_press0;
        rst  = 1'b1;
        raw0 = 1'b0;
        step(1);  chk("t6_rst_press", int'(pp0), 0);
        chk("t6_rst_level", int'(lvl0), 0);
        rst = 1'b0;
        step(12); chk("t6_no_press_after_rst", n_press0 - snap_p, 0);

        // Active-low pad: driving it low is a press.
        raw1 = 1'b0;
        step(6);  chk("t6_al_no_press_e6", int'(pp1), 0);
        step(1);  chk("t6_al_press_e7", int'(pp1), 1);
        chk("t6_al_level", int'(lvl1), 1);
        raw1 = 1'b1;
        step(7);  chk("t6_al_release_r7", int'(rp1), 1);
        step(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
